// File: rtl/cache_inval_seq.sv
// Tag RAM invalidate sequencer: sweeps every line of a direct-mapped tag RAM,
// clearing valid bits, on a software request or a bypass 1->0 transition.
module cache_inval_seq #(
  parameter int LINE_NUM = 256,
  parameter int TAG_W    = 20,
  localparam int IDX_W   = $clog2(LINE_NUM)
) (
  input  logic             i_hclk,
  input  logic             i_hreset,
  input  logic             i_bypass,
  input  logic             i_cache_dis,
  input  logic             i_inval_req,
  input  logic             i_tag_ack,
  output logic             o_tag_we,
  output logic [IDX_W-1:0] o_tag_idx,
  output logic [TAG_W:0]   o_tag_wdata,
  output logic             o_busy,
  output logic             o_cache_hold,
  output logic             o_done,
  output logic [15:0]      o_inval_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_NUM - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             bypass_q;
  logic [15:0]      cnt_q, cnt_d;
  logic             trig_s;

  assign trig_s = i_inval_req | (bypass_q & ~i_bypass);

  // State registers; bypass_q resets to 1 so a bypass held low through reset still triggers.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      bypass_q <= 1'b1;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      bypass_q <= i_bypass;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; triggers arriving mid-sweep collapse into a single pending restart.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (trig_s) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (i_tag_ack) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DONE: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
        pend_d = 1'b0;
        if (pend_q | trig_s) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign o_tag_we     = (state_q == ST_SWEEP);
  assign o_tag_idx    = idx_q;
  assign o_tag_wdata  = '0;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  // Hold follows the live bypass/disable inputs so lookups resume without a cycle of lag.
  assign o_cache_hold = o_busy & ~i_bypass & ~i_cache_dis;
  assign o_inval_cnt  = cnt_q;

endmodule

// File: tb/tb_cache_inval_seq.sv
// Scoreboard bench for cache_inval_seq: expected tag-write indices and sweep
// counts are queued at stimulus time and popped as the DUT performs them.
module tb_cache_inval_seq;

  localparam int LINE_NUM = 256;
  localparam int TAG_W    = 20;
  localparam int IDX_W    = $clog2(LINE_NUM);

  logic             clk = 1'b0;
  logic             i_hreset = 1'b1;
  logic             i_bypass = 1'b1;
  logic             i_cache_dis = 1'b0;
  logic             i_inval_req = 1'b0;
  logic             i_tag_ack = 1'b1;
  logic             o_tag_we;
  logic [IDX_W-1:0] o_tag_idx;
  logic [TAG_W:0]   o_tag_wdata;
  logic             o_busy;
  logic             o_cache_hold;
  logic             o_done;
  logic [15:0]      o_inval_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cycles, busy_cycles, done_pulses;
  logic ack_mode = 1'b0;
  logic cnt_chk  = 1'b0;
  int exp_idx[$];
  int exp_cnt[$];

  cache_inval_seq #(.LINE_NUM(LINE_NUM), .TAG_W(TAG_W)) dut (
    .i_hclk(clk), .i_hreset(i_hreset), .i_bypass(i_bypass),
    .i_cache_dis(i_cache_dis), .i_inval_req(i_inval_req), .i_tag_ack(i_tag_ack),
    .o_tag_we(o_tag_we), .o_tag_idx(o_tag_idx), .o_tag_wdata(o_tag_wdata),
    .o_busy(o_busy), .o_cache_hold(o_cache_hold), .o_done(o_done),
    .o_inval_cnt(o_inval_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep(input logic [15:0] cnt_after);
    for (int i = 0; i < LINE_NUM; i++) exp_idx.push_back(i);
    exp_cnt.push_back(int'(cnt_after));
  endtask

  task automatic clr_stats();
    we_cycles = 0;
    busy_cycles = 0;
    done_pulses = 0;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 i_inval_req = 1'b1;
    @(posedge clk); #1 i_inval_req = 1'b0;
  endtask

  task automatic wait_idx(input int v);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_tag_we && int'(o_tag_idx) == v) return;
    end
    check("timeout_idx", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    logic seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_busy) seen = 1'b1;
      else if (seen) return;
    end
    check("timeout_idle", 32'd0, 32'd1);
  endtask

  // Ack driver: tied high, or alternating 1,0,1,... starting on the first sweep cycle.
  initial forever begin
    @(posedge clk); #1;
    if (ack_mode) i_tag_ack = o_tag_we ? ~i_tag_ack : 1'b0;
    else i_tag_ack = 1'b1;
  end

  // Monitor: pops expected index per accepted write and expected count after each done.
  initial forever begin
    @(negedge clk);
    if (cnt_chk) begin
      cnt_chk = 1'b0;
      if (exp_cnt.size() == 0) check("cnt_unexp", 32'd1, 32'd0);
      else check("sweep_cnt", 32'(o_inval_cnt), exp_cnt.pop_front());
    end
    if (o_done) begin
      cnt_chk = 1'b1;
      done_pulses++;
    end
    if (o_tag_we) we_cycles++;
    if (o_busy) busy_cycles++;
    if (o_tag_we && i_tag_ack) begin
      if (exp_idx.size() == 0) check("idx_unexp", 32'd1, 32'd0);
      else check("tag_idx", 32'(o_tag_idx), exp_idx.pop_front());
      if (o_tag_wdata != '0) check("wdata", 32'(o_tag_wdata), 32'd0);
    end
  end

  initial begin
    clr_stats();
    repeat (2) @(posedge clk);
    #1 i_hreset = 1'b0;
    @(negedge clk);
    check("rst_we", 32'(o_tag_we), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_hold", 32'(o_cache_hold), 32'd0);
    check("rst_cnt", 32'(o_inval_cnt), 32'd0);

    // bypass 1->0 triggers a full sweep, ack tied high
    clr_stats();
    push_sweep(16'd1);
    @(posedge clk); #1 i_bypass = 1'b0;
    @(negedge clk);
    check("lat_pre_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("lat_we", 32'(o_tag_we), 32'd1);
    check("lat_idx", 32'(o_tag_idx), 32'd0);
    check("lat_hold", 32'(o_cache_hold), 32'd1);
    wait_idle();
    @(negedge clk);
    check("t1_we_cycles", 32'(we_cycles), 32'd256);
    check("t1_busy_cycles", 32'(busy_cycles), 32'd257);
    check("t1_done", 32'(done_pulses), 32'd1);
    check("t1_cnt", 32'(o_inval_cnt), 32'd1);

    // alternating ack: every index held until acked
    clr_stats();
    ack_mode = 1'b1;
    push_sweep(16'd2);
    pulse_req();
    wait_idle();
    @(negedge clk);
    ack_mode = 1'b0;
    check("t2_we_cycles", 32'(we_cycles), 32'd511);
    check("t2_busy_cycles", 32'(busy_cycles), 32'd512);
    check("t2_done", 32'(done_pulses), 32'd1);

    // two mid-sweep requests collapse into exactly one restart
    clr_stats();
    push_sweep(16'd3);
    pulse_req();
    wait_idx(100);
    i_inval_req = 1'b1;
    push_sweep(16'd4);
    @(posedge clk); #1 i_inval_req = 1'b0;
    wait_idx(200);
    i_inval_req = 1'b1;
    @(posedge clk); #1 i_inval_req = 1'b0;
    wait_idle();
    @(negedge clk);
    check("t3_done", 32'(done_pulses), 32'd2);
    check("t3_we_cycles", 32'(we_cycles), 32'd512);
    check("t3_cnt", 32'(o_inval_cnt), 32'd4);

    // bypass rising mid-sweep drops hold at once, sweep continues
    clr_stats();
    push_sweep(16'd5);
    pulse_req();
    wait_idx(49);
    check("t4_hold_on", 32'(o_cache_hold), 32'd1);
    @(negedge clk);
    i_bypass = 1'b1;
    #1;
    check("t4_hold_off", 32'(o_cache_hold), 32'd0);
    check("t4_busy", 32'(o_busy), 32'd1);
    wait_idle();
    @(negedge clk);
    check("t4_we_cycles", 32'(we_cycles), 32'd256);

    // cache disable masks hold only
    push_sweep(16'd6);
    i_cache_dis = 1'b1;
    @(posedge clk); #1 i_bypass = 1'b0;
    wait_idx(10);
    check("t5_hold_dis", 32'(o_cache_hold), 32'd0);
    check("t5_busy", 32'(o_busy), 32'd1);
    i_cache_dis = 1'b0;
    #1;
    check("t5_hold_en", 32'(o_cache_hold), 32'd1);
    wait_idle();
    @(negedge clk);
    check("t5_cnt", 32'(o_inval_cnt), 32'd6);

    // reset mid-sweep abandons it; bypass held low restarts from index 0
    push_sweep(16'd7);
    pulse_req();
    wait_idx(128);
    #1 i_hreset = 1'b1;
    @(posedge clk); #1 i_hreset = 1'b0;
    exp_idx.delete();
    exp_cnt.delete();
    clr_stats();
    push_sweep(16'd1);
    @(negedge clk);
    check("t6_we", 32'(o_tag_we), 32'd0);
    check("t6_busy", 32'(o_busy), 32'd0);
    check("t6_cnt", 32'(o_inval_cnt), 32'd0);
    @(negedge clk);
    check("t6_restart_we", 32'(o_tag_we), 32'd1);
    check("t6_restart_idx", 32'(o_tag_idx), 32'd0);
    wait_idle();
    @(negedge clk);
    check("t6_we_cycles", 32'(we_cycles), 32'd256);
    check("t6_cnt_after", 32'(o_inval_cnt), 32'd1);

    // count saturation
    force dut.cnt_q = 16'hFFFE;
    @(posedge clk); #1 release dut.cnt_q;
    @(negedge clk);
    check("t7_preset", 32'(o_inval_cnt), 32'h0000FFFE);
    for (int s = 0; s < 3; s++) begin
      push_sweep(16'hFFFF);
      pulse_req();
      wait_idle();
      @(negedge clk);
      check("t7_sat", 32'(o_inval_cnt), 32'h0000FFFF);
    end

    @(negedge clk);
    check("sb_idx_empty", 32'(exp_idx.size()), 32'd0);
    check("sb_cnt_empty", 32'(exp_cnt.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_inval_seq.md
Name: cache_inval_seq

Overview:
- Invalidate sequencer that sits directly downstream of the cache AHB config block.
- Consumes the config outputs bypass/cache-disable plus a software invalidate pulse.
- Walks every line of the direct-mapped tag RAM, clearing valid bits through a write handshake.
- Stalls cache lookups while the sweep runs and reports a saturating sweep count for the status register.

Parameters:
LINE_NUM, 256, number of cache lines; power of two, >= 2
IDX_W, $clog2(LINE_NUM), tag RAM index width (derived; not overridden)
TAG_W, 20, tag field width; tag write word is TAG_W+1 bits with the valid bit as MSB

Ports:
- i_hclk, input, 1: clock; all logic is rising-edge.
- i_hreset, input, 1: reset, synchronous, active-high.
- i_bypass, input, 1: cache bypass from the config block; 1 = bypassed.
- i_cache_dis, input, 1: cache disable from the config block.
- i_inval_req, input, 1: single-cycle software invalidate request.
- i_tag_ack, input, 1: tag RAM accepted the current write.
- o_tag_we, output, 1: tag write request.
- o_tag_idx, output, IDX_W: line index being invalidated.
- o_tag_wdata, output, TAG_W+1: write word, always all zeros (valid=0, tag=0).
- o_busy, output, 1: sweep in progress.
- o_cache_hold, output, 1: stalls cache lookups; equals o_busy & !i_bypass & !i_cache_dis.
- o_done, output, 1: one-cycle pulse when a sweep completes.
- o_inval_cnt, output, 16: count of completed sweeps; saturates at 16'hFFFF.

Behaviour:
- Reset (sync, i_hreset=1 at a rising edge):
  - State is IDLE, index 0, pending flag 0, count 0.
  - bypass_q is 1, matching the config block's bypassed default.
  - o_tag_we, o_busy, o_done and o_cache_hold are all 0.
- Reset overrides everything, including a sweep in progress. The sweep is abandoned with no further tag writes.
- Trigger:
  - trig = i_inval_req | (bypass_q & !i_bypass), i.e. the request pulse or a bypass 1->0 transition.
  - bypass_q <= i_bypass every cycle.
- States: IDLE, SWEEP, DONE (2-bit encoding).
- IDLE:
  - If trig, go to SWEEP with index 0. Otherwise stay.
  - Latency: trig sampled at edge N gives o_tag_we=1 and o_busy=1 during cycle N+1.
- SWEEP:
  - o_tag_we=1 and o_tag_idx=index, both held stable until i_tag_ack.
  - On i_tag_ack with index==LINE_NUM-1, go to DONE. On i_tag_ack otherwise, index+1 and stay in SWEEP.
  - Without i_tag_ack, hold the state and index.
  - A full sweep takes at least LINE_NUM cycles when ack is tied high.
- DONE (one cycle):
  - o_done=1, o_busy=1, o_tag_we=0.
  - o_inval_cnt increments unless it is already 16'hFFFF.
  - If pending=1, go to SWEEP with index 0 and clear pending. Otherwise go to IDLE.
- Triggers while not IDLE (SWEEP or DONE):
  - They set pending; multiple triggers collapse to one.
  - They never restart or abort the current sweep.
  - A trigger in the same DONE cycle as a pending=0 check still causes a restart, because the trigger is ORed into the pending decision.
- i_bypass returning to 1 mid-sweep:
  - The sweep continues to completion.
  - o_cache_hold drops immediately, since it is combinational on i_bypass.
- i_cache_dis does not affect sequencing; it only masks o_cache_hold.
- Index arithmetic: IDX_W bits, compared against LINE_NUM-1 and never wrapping past it. The index resets to 0 on every sweep start.
- o_tag_wdata is constant 0. There are no X outputs in any state.

Test Plan:
- Reset, then drive i_bypass 1->0 with i_tag_ack=1 and LINE_NUM=256:
  - o_tag_we is high for exactly 256 cycles with o_tag_idx 0..255 in order.
  - o_done pulses once in the next cycle.
  - o_inval_cnt reads 1, and o_busy is high for 257 cycles.
- i_inval_req pulse with i_tag_ack toggling 1,0,1,0:
  - Each index is held until acked; no index is skipped or repeated.
  - The sweep finishes in 511 cycles.
- i_inval_req at index 100, then again at index 200:
  - The sweep completes to 255 and o_done pulses.
  - Exactly one more sweep starts at index 0, then returns to IDLE.
  - o_inval_cnt is 2.
- Mid-sweep changes:
  - i_bypass=0, then 1 at index 50: the sweep reaches 255, and o_cache_hold falls in the same cycle as i_bypass rises.
  - i_cache_dis=1 with i_bypass=0: o_cache_hold=0 while o_busy=1.
- Assert i_hreset for one edge at index 128:
  - The next cycle shows o_tag_we=0, o_busy=0, o_inval_cnt=0.
  - With i_bypass held 0 through reset, a new sweep starts from index 0 (bypass_q resets to 1, so the edge is seen).
- Force o_inval_cnt to 16'hFFFE, then run 3 sweeps: it reads 16'hFFFF and stays there.
